dot_product_accum: RTL and testbench

- Sequential accumulator directly downstream of the 16-bit signed multiplier stage.
- Consumes a stream of signed 16-bit products, one per accepted beat, and sums a programmed number of them into a wide accumulator.
- Presents the saturated 16-bit dot-product result with a valid/ready handshake.
- Used by the correlation step to form inner products of a residual with dictionary columns.

---
 rtl/dot_product_accum_if.sv | 35 +++
 rtl/dot_product_accum.sv | 154 +++++++++++++++
 tb/tb_dot_product_accum.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_accum_if
// Brief    : Command, product-stream and result handshake bundle for the
//            dot-product accumulator. The master drives the requests and the
//            products; the slave returns the result.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_product_accum_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic signed [15:0]      p_in;
    logic                    p_valid;
    logic                    p_ready;
    logic                    out_ready;
    logic                    out_valid;
    logic signed [15:0]      acc_out;
    logic signed [ACC_W-1:0] acc_full;
    logic                    overflow;

    modport master (
        output start, len, p_in, p_valid, out_ready,
        input  busy, p_ready, out_valid, acc_out, acc_full, overflow
    );

    modport slave (
        input  start, len, p_in, p_valid, out_ready,
        output busy, p_ready, out_valid, acc_out, acc_full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_accum.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_accum
// Brief    : Sums a programmed number of signed 16-bit products into a
//            saturating ACC_W-bit accumulator and returns the result clipped
//            to signed 16 bits over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_accum #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dot_product_accum_if.slave bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0]        r_cnt;
    logic signed [15:0]      r_acc_out;
    logic                    r_overflow;
    logic                    r_out_valid;
    logic                    r_busy;

    logic                    w_xfer;
    logic                    w_last;
    logic [ACC_W:0]          w_sum;
    logic                    w_sat;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [ACC_W-16:0]       w_hi;
    logic                    w_fits;
    logic signed [15:0]      w_clip;

    // p_ready is a pure function of state so the upstream never sees an
    // input-to-output path through this block.
    assign bus.p_ready   = (r_state == c_st_accum);
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.acc_out   = r_acc_out;
    assign bus.acc_full  = r_acc;
    assign bus.overflow  = r_overflow;

    assign w_xfer = bus.p_valid && (r_state == c_st_accum);
    assign w_last = (r_cnt == LEN_W'(1));

    // Saturating add one bit wider than the accumulator, then 16-bit clip.
    always_comb begin
        w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-15){bus.p_in[15]}}, bus.p_in};
        w_sat      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_sat) begin
            w_acc_next = w_sum[ACC_W] ? c_acc_min : c_acc_max;
        end
        w_hi   = w_acc_next[ACC_W-1:15];
        w_fits = (&w_hi) | ~(|w_hi);
        w_clip = w_acc_next[15:0];
        if (!w_fits) begin
            w_clip = w_acc_next[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start only counts in IDLE, a zero length skips ACCUM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_next_state = (bus.len == '0) ? c_st_done : c_st_accum;
                end
            end
            c_st_accum: begin
                if (w_xfer && w_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                if (bus.out_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Datapath and registered outputs; the result is formed on the last beat
    // so DONE only has to hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_out   <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_cnt       <= bus.len;
                        r_acc       <= '0;
                        r_acc_out   <= '0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_out_valid <= (bus.len == '0);
                    end
                end
                c_st_accum: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (w_sat) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_last) begin
                            r_acc_out   <= w_clip;
                            r_overflow  <= r_overflow | w_sat | ~w_fits;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_accum
// Brief    : Directed bench for dot_product_accum. Two instances (ACC_W=24 and
//            ACC_W=17) run the same stimulus; each result is checked against
//            hand-computed values queued when the vector is issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_accum;

    typedef struct {
        longint full;
        longint out;
        longint ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    dot_product_accum_if #(.ACC_W(24), .LEN_W(8)) bus_a ();
    dot_product_accum_if #(.ACC_W(17), .LEN_W(8)) bus_b ();

    assign bus_b.start     = bus_a.start;
    assign bus_b.len       = bus_a.len;
    assign bus_b.p_in      = bus_a.p_in;
    assign bus_b.p_valid   = bus_a.p_valid;
    assign bus_b.out_ready = bus_a.out_ready;

    dot_product_accum #(.ACC_W(24), .LEN_W(8)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dot_product_accum #(.ACC_W(17), .LEN_W(8)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input longint fa, input longint fb, input longint o, input longint ov);
        exp_t e;
        e.full = fa; e.out = o; e.ov = ov;
        q_a.push_back(e);
        e.full = fb;
        q_b.push_back(e);
    endtask

    task automatic start_vec(input int n);
        bus_a.start = 1'b1;
        bus_a.len   = 8'(n);
        tick();
        bus_a.start = 1'b0;
    endtask

    task automatic beat(input int p, input int stall);
        int n;
        bus_a.p_valid = 1'b0;
        repeat (stall) tick();
        bus_a.p_in    = 16'(p);
        bus_a.p_valid = 1'b1;
        n = 0;
        while (!bus_a.p_ready && n < 20) begin
            tick();
            n++;
        end
        chk("p_ready_on_beat", longint'(bus_a.p_ready), 1);
        tick();
    endtask

    task automatic accept(input int hold, input logic with_start);
        int n;
        bus_a.out_ready = 1'b0;
        repeat (hold) tick();
        n = 0;
        while (!bus_a.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("out_valid_before_accept", longint'(bus_a.out_valid), 1);
        bus_a.out_ready = 1'b1;
        bus_a.start     = with_start;
        bus_a.len       = 8'd9;
        tick();
        bus_a.out_ready = 1'b0;
        bus_a.start     = 1'b0;
        chk("idle_out_valid", longint'(bus_a.out_valid), 0);
        chk("idle_busy", longint'(bus_a.busy), 0);
    endtask

    // Scoreboard monitor: every cycle a result is presented it must match the
    // queue head; the entry retires on the accepting cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.out_valid) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_result", 1, 0);
                end else begin
                    chk("a_acc_full", longint'(bus_a.acc_full), q_a[0].full);
                    chk("a_acc_out", longint'(bus_a.acc_out), q_a[0].out);
                    chk("a_overflow", longint'(bus_a.overflow), q_a[0].ov);
                    if (bus_a.out_ready) void'(q_a.pop_front());
                end
            end
            if (bus_b.out_valid) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_result", 1, 0);
                end else begin
                    chk("b_acc_full", longint'(bus_b.acc_full), q_b[0].full);
                    chk("b_acc_out", longint'(bus_b.acc_out), q_b[0].out);
                    chk("b_overflow", longint'(bus_b.overflow), q_b[0].ov);
                    if (bus_b.out_ready) void'(q_b.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.start     = 1'b0;
        bus_a.len       = '0;
        bus_a.p_in      = '0;
        bus_a.p_valid   = 1'b0;
        bus_a.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", longint'(bus_a.busy), 0);
        chk("rst_p_ready", longint'(bus_a.p_ready), 0);
        chk("rst_out_valid", longint'(bus_a.out_valid), 0);
        chk("rst_acc_full", longint'(bus_a.acc_full), 0);
        chk("rst_acc_out", longint'(bus_a.acc_out), 0);
        chk("rst_overflow", longint'(bus_a.overflow), 0);
        tick();

        // Basic sum, back-to-back beats, one-cycle latency
        expect_res(80, 80, 80, 0);
        start_vec(4);
        chk("accum_busy", longint'(bus_a.busy), 1);
        beat(100, 0);
        beat(-30, 0);
        beat(7, 0);
        chk("no_early_valid", longint'(bus_a.out_valid), 0);
        beat(3, 0);
        bus_a.p_valid = 1'b0;
        chk("latency_valid", longint'(bus_a.out_valid), 1);
        chk("done_p_ready", longint'(bus_a.p_ready), 0);
        accept(0, 1'b0);

        // Stalls between beats and backpressure with stray p_valid in DONE
        expect_res(6000, 6000, 6000, 0);
        start_vec(3);
        beat(1000, 0);
        beat(2000, 2);
        beat(3000, 2);
        bus_a.p_in    = 16'sd999;
        bus_a.p_valid = 1'b1;
        chk("stall_valid", longint'(bus_a.out_valid), 1);
        accept(5, 1'b0);
        bus_a.p_valid = 1'b0;

        // Output clip, positive then negative; ACC_W=17 also saturates
        expect_res(98301, 65535, 32767, 1);
        start_vec(3);
        repeat (3) beat(32767, 0);
        bus_a.p_valid = 1'b0;
        accept(1, 1'b0);

        expect_res(-98304, -65536, -32768, 1);
        start_vec(3);
        repeat (3) beat(-32768, 0);
        bus_a.p_valid = 1'b0;
        accept(1, 1'b0);

        // Accumulator saturation (ACC_W=17) vs clip only (ACC_W=24)
        expect_res(131068, 65535, 32767, 1);
        start_vec(4);
        repeat (4) beat(32767, 0);
        bus_a.p_valid = 1'b0;
        accept(0, 1'b0);

        // Zero length: result the cycle after start
        expect_res(0, 0, 0, 0);
        start_vec(0);
        chk("zero_len_valid", longint'(bus_a.out_valid), 1);
        chk("zero_len_busy", longint'(bus_a.busy), 1);
        accept(0, 1'b0);

        // start ignored during ACCUM and on the accept cycle
        expect_res(30, 30, 30, 0);
        start_vec(2);
        bus_a.start = 1'b1;
        bus_a.len   = 8'd7;
        beat(10, 0);
        bus_a.start = 1'b0;
        beat(20, 0);
        bus_a.p_valid = 1'b0;
        chk("ignored_start_valid", longint'(bus_a.out_valid), 1);
        accept(0, 1'b1);
        tick();
        chk("stay_idle_busy", longint'(bus_a.busy), 0);
        chk("stay_idle_valid", longint'(bus_a.out_valid), 0);

        // Reset mid-vector abandons it
        start_vec(5);
        beat(1, 0);
        beat(2, 0);
        bus_a.p_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", longint'(bus_a.busy), 0);
        chk("midrst_p_ready", longint'(bus_a.p_ready), 0);
        chk("midrst_out_valid", longint'(bus_a.out_valid), 0);
        chk("midrst_acc_full_a", longint'(bus_a.acc_full), 0);
        chk("midrst_acc_full_b", longint'(bus_b.acc_full), 0);
        expect_res(-5, -5, -5, 0);
        start_vec(1);
        beat(-5, 0);
        bus_a.p_valid = 1'b0;
        accept(0, 1'b0);

        tick();
        chk("q_a_drained", longint'(q_a.size()), 0);
        chk("q_b_drained", longint'(q_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
